// File: rtl/matrix_pkg.sv
// Shared defaults and pixel addressing for the LED matrix scan driver.
package matrix_pkg;

  localparam int unsigned DEF_ROWS          = 7;
  localparam int unsigned DEF_COLS          = 5;
  localparam int unsigned DEF_SCAN_DIV      = 1000;
  localparam int unsigned DEF_SCROLL_FRAMES = 16;

  // Flat bit position of pixel (column c, row r) inside an image vector.
  function automatic int unsigned pix_idx(input int unsigned c,
                                          input int unsigned r,
                                          input int unsigned rows);
    return c * rows + r;
  endfunction

endpackage

// File: rtl/matrix_scan_timer.sv
// Column scan timing: per-column hold divider, column index, frame boundary and frame_start.
module scan_timer
  import matrix_pkg::*;
#(
  parameter int unsigned COLS     = DEF_COLS,
  parameter int unsigned SCAN_DIV = DEF_SCAN_DIV,
  localparam int unsigned CW      = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned DW      = $clog2(SCAN_DIV)
)(
  input  logic            clk,
  input  logic            rst,
  output logic [CW-1:0]   o_col_idx,
  output logic [COLS-1:0] o_col_sel,
  output logic            o_frame_tick,
  output logic            o_frame_start
);

  logic [DW-1:0]   r_div;
  logic [CW-1:0]   r_col;
  logic [COLS-1:0] r_col_sel;
  logic            r_tick_d;
  logic            r_frame_start;
  logic            w_div_tc;
  logic            w_last_col;

  assign w_div_tc   = (r_div == DW'(SCAN_DIV - 1));
  assign w_last_col = (r_col == CW'(COLS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div         <= '0;
      r_col         <= '0;
      r_col_sel     <= COLS'(1);
      r_tick_d      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div <= w_div_tc ? '0 : r_div + DW'(1);
      if (w_div_tc)
        r_col <= w_last_col ? '0 : r_col + CW'(1);
      r_col_sel     <= COLS'(1) << r_col;
      // Boundary -> column 0 one cycle later -> col_sel bit 0 one cycle after that.
      r_tick_d      <= w_div_tc && w_last_col;
      r_frame_start <= r_tick_d;
    end
  end

  assign o_col_idx     = r_col;
  assign o_col_sel     = r_col_sel;
  assign o_frame_tick  = w_div_tc && w_last_col;
  assign o_frame_start = r_frame_start;

endmodule

// File: rtl/matrix_scan_driver.sv
// LED matrix scan driver: serial back buffer, commit-at-frame-boundary publish, optional left scroll.
module matrix_scan_driver
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS          = DEF_ROWS,
  parameter int unsigned COLS          = DEF_COLS,
  parameter int unsigned SCAN_DIV      = DEF_SCAN_DIV,
  parameter int unsigned SCROLL_FRAMES = DEF_SCROLL_FRAMES
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_valid,
  input  logic            wr_bit,
  input  logic            commit,
  input  logic            scroll_en,
  input  logic            invert,
  output logic [COLS-1:0] col_sel,
  output logic [ROWS-1:0] row_data,
  output logic            frame_start,
  output logic            wr_full,
  output logic            commit_pending,
  output logic            commit_err
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned NW = $clog2(N + 1);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned SW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  logic [N-1:0]    r_back;
  logic [N-1:0]    r_active;
  logic [NW-1:0]   r_cnt;
  logic [SW-1:0]   r_scroll;
  logic            r_pending;
  logic            r_err;
  logic [ROWS-1:0] r_row_data;

  logic [CW-1:0]   w_col_idx;
  logic            w_frame_tick;
  logic            w_full;
  logic            w_publish;
  logic            w_scroll_due;
  logic            w_rotate;
  logic [IW-1:0]   w_base;

  scan_timer #(
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_timer (
    .clk           (clk),
    .rst           (rst),
    .o_col_idx     (w_col_idx),
    .o_col_sel     (col_sel),
    .o_frame_tick  (w_frame_tick),
    .o_frame_start (frame_start)
  );

  assign w_full       = (r_cnt == NW'(N));
  assign w_publish    = w_frame_tick && r_pending;
  assign w_scroll_due = (r_scroll == SW'(SCROLL_FRAMES - 1));
  assign w_rotate     = w_frame_tick && scroll_en && !r_pending && w_scroll_due;
  assign w_base       = IW'(pix_idx(32'(w_col_idx), 0, ROWS));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_back     <= '0;
      r_active   <= '0;
      r_cnt      <= '0;
      r_scroll   <= '0;
      r_pending  <= 1'b0;
      r_err      <= 1'b0;
      r_row_data <= '0;
    end else begin
      if (wr_valid)
        r_back <= {r_back[N-2:0], wr_bit};

      // A write landing on the publish cycle is the first bit of the next image.
      if (w_publish)
        r_cnt <= wr_valid ? NW'(1) : '0;
      else if (wr_valid && !w_full)
        r_cnt <= r_cnt + NW'(1);

      if (w_publish)
        r_pending <= 1'b0;
      else if (commit && !r_pending && w_full)
        r_pending <= 1'b1;
      r_err <= commit && !r_pending && !w_full;

      if (w_publish)
        r_active <= r_back;
      else if (w_rotate)
        r_active <= {r_active[ROWS-1:0], r_active[N-1:ROWS]};

      if (w_publish || !scroll_en)
        r_scroll <= '0;
      else if (w_frame_tick)
        r_scroll <= w_scroll_due ? '0 : r_scroll + SW'(1);

      r_row_data <= r_active[w_base +: ROWS] ^ {ROWS{invert}};
    end
  end

  assign row_data       = r_row_data;
  assign wr_full        = w_full;
  assign commit_pending = r_pending;
  assign commit_err     = r_err;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Scoreboarded bench for matrix_scan_driver: expected frames queued at commit time, checked per scan cycle.
module tb_matrix_scan_driver;

  localparam int unsigned ROWS = 7;
  localparam int unsigned COLS = 5;
  localparam int unsigned SDIV = 4;
  localparam int unsigned SFR  = 2;
  localparam int unsigned N    = ROWS * COLS;

  logic            clk = 1'b0;
  logic            rst, wr_valid, wr_bit, commit, scroll_en, invert;
  logic [COLS-1:0] col_sel;
  logic [ROWS-1:0] row_data;
  logic            frame_start, wr_full, commit_pending, commit_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [N-1:0] exp_q[$];

  always #5 clk = ~clk;

  matrix_scan_driver #(
    .ROWS          (ROWS),
    .COLS          (COLS),
    .SCAN_DIV      (SDIV),
    .SCROLL_FRAMES (SFR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_valid       (wr_valid),
    .wr_bit         (wr_bit),
    .commit         (commit),
    .scroll_en      (scroll_en),
    .invert         (invert),
    .col_sel        (col_sel),
    .row_data       (row_data),
    .frame_start    (frame_start),
    .wr_full        (wr_full),
    .commit_pending (commit_pending),
    .commit_err     (commit_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_fs(input string tag);
    int unsigned i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!frame_start && i < 64);
    chk({tag, "_fs"}, 32'(frame_start), 32'd1);
  endtask

  // Pops one expected image and compares every cycle of the next frame.
  task automatic check_frame(input string tag);
    logic [N-1:0]    img;
    logic [COLS-1:0] oh;
    int              c;
    img = exp_q.pop_front();
    wait_fs(tag);
    for (int i = 0; i < int'(COLS * SDIV); i++) begin
      if (i > 0) @(negedge clk);
      c     = i / int'(SDIV);
      oh    = '0;
      oh[c] = 1'b1;
      chk(tag, 32'({frame_start, col_sel, row_data}),
          32'({(i == 0), oh, img[c*ROWS +: ROWS]}));
    end
  endtask

  // The k-th bit written is the one that ends at image bit N-1-k.
  task automatic write_bits(input logic [N-1:0] img, input int first, input int cnt);
    for (int k = first; k < first + cnt; k++) begin
      wr_valid = 1'b1;
      wr_bit   = img[N-1-k];
      @(negedge clk);
    end
    wr_valid = 1'b0;
    wr_bit   = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic wait_pending_clear(input string tag);
    int unsigned i = 0;
    while (commit_pending && i < 64) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 32'(commit_pending), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] img37, img38, img39, img40, img41;
    rst = 1'b1; wr_valid = 1'b0; wr_bit = 1'b0; commit = 1'b0;
    scroll_en = 1'b0; invert = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({frame_start, col_sel, row_data, wr_full, commit_pending, commit_err}),
        32'({1'b0, 5'b00001, 7'h00, 3'b000}));
    rst = 1'b0;

    // Idle scan: blank display, back-to-back frames of 20 cycles.
    exp_q.push_back('0);
    exp_q.push_back('0);
    check_frame("idle0");
    check_frame("idle1");

    // Alternating pattern, then one inverted frame.
    for (int k = 0; k < int'(N); k++) img37[N-1-k] = 1'(k % 2);
    write_bits(img37, 0, N);
    chk("full_35", 32'(wr_full), 32'd1);
    do_commit();
    chk("pend_set", 32'(commit_pending), 32'd1);
    chk("no_err", 32'(commit_err), 32'd0);
    wait_pending_clear("pend_clr37");
    chk("full_clr", 32'(wr_full), 32'd0);
    exp_q.push_back(img37);
    check_frame("img37");
    invert = 1'b1;
    exp_q.push_back(~img37);
    check_frame("inv37");
    invert = 1'b0;

    // Early commit rejected; completing the image then commit accepted.
    img38 = 35'h5_A5C3_0F1E;
    write_bits(img38, 0, N - 1);
    chk("full_34", 32'(wr_full), 32'd0);
    do_commit();
    chk("err_pulse", 32'(commit_err), 32'd1);
    chk("err_no_pend", 32'(commit_pending), 32'd0);
    @(negedge clk);
    chk("err_drop", 32'(commit_err), 32'd0);
    exp_q.push_back(img37);
    check_frame("hold37");
    write_bits(img38, N - 1, 1);
    chk("full_35b", 32'(wr_full), 32'd1);
    do_commit();
    chk("pend38", 32'(commit_pending), 32'd1);
    wait_pending_clear("pend_clr38");
    exp_q.push_back(img38);
    check_frame("img38");

    // Single lit column 0 scrolling left every 2 frames.
    img39 = 35'h7F;
    write_bits(img39, 0, N);
    scroll_en = 1'b1;
    do_commit();
    wait_pending_clear("pend_clr39");
    exp_q.push_back(img39);
    exp_q.push_back(img39);
    exp_q.push_back(35'h7F << 28);
    exp_q.push_back(35'h7F << 28);
    exp_q.push_back(35'h7F << 21);
    check_frame("scr0");
    check_frame("scr1");
    check_frame("scr2");
    check_frame("scr3");
    check_frame("scr4");

    // Publish and due scroll at the same boundary, with a write on that cycle.
    scroll_en = 1'b0;
    img40 = 35'h2_9A5C_3E17;
    write_bits(img40, 0, N);
    wait_fs("t40a");
    scroll_en = 1'b1;
    wait_fs("t40b");
    do_commit();
    chk("pend40", 32'(commit_pending), 32'd1);
    repeat (17) @(negedge clk);
    chk("pend40_hold", 32'(commit_pending), 32'd1);
    chk("col_last", 32'(col_sel), 32'h10);
    wr_valid = 1'b1;
    wr_bit   = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("pend40_pub", 32'(commit_pending), 32'd0);
    exp_q.push_back(img40);
    exp_q.push_back(img40);
    exp_q.push_back({img40[ROWS-1:0], img40[N-1:ROWS]});
    check_frame("pri0");
    check_frame("pri1");
    check_frame("pri2");
    write_bits(img40, 0, N - 2);
    chk("cnt_34", 32'(wr_full), 32'd0);
    write_bits(img40, 0, 1);
    chk("cnt_35", 32'(wr_full), 32'd1);

    // Reset while a commit is pending discards it.
    scroll_en = 1'b0;
    img41 = '1;
    write_bits(img41, 0, N);
    wait_fs("t41");
    do_commit();
    chk("pend41", 32'(commit_pending), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid", 32'({frame_start, col_sel, row_data, wr_full, commit_pending, commit_err}),
        32'({1'b0, 5'b00001, 7'h00, 3'b000}));
    @(negedge clk);
    rst = 1'b0;
    chk("rst_pend", 32'(commit_pending), 32'd0);
    chk("rst_full", 32'(wr_full), 32'd0);
    exp_q.push_back('0);
    exp_q.push_back('0);
    check_frame("blank0");
    check_frame("blank1");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
